// File: rtl/decoder_scheduler_pkg.sv
// Shared constants, FSM state type and round-robin helper for the decoder
// scheduler. Holds the codeword / data / size widths and the largest legal
// size code that the shared decoder accepts.
package decoder_pkg;

  localparam int CW_W = 14;
  localparam int DW_W = 7;
  localparam int SZ_W = 3;
  localparam logic [SZ_W-1:0] MAX_SIZE = SZ_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Next round-robin position after ptr, wrapping at n.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/decoder_scheduler_if.sv
// Requester-side job/response bundle of the decoder scheduler.
//   req_valid/req_ready  : per-requester job handshake (ready is one-hot)
//   req_string/req_size  : packed per-requester codeword and size code
//   rsp_valid/rsp_ready  : per-requester response handshake (valid is one-hot)
//   rsp_data/rsp_err     : shared response payload
// master = requester side, slave = scheduler side.
interface decoder_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import decoder_pkg::*;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*CW_W-1:0] req_string;
  logic [NUM_REQ*SZ_W-1:0] req_size;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [DW_W-1:0]         rsp_data;
  logic                    rsp_err;

  modport master (
    output req_valid, req_string, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_string, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/decoder_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req_i   : request vector
//   ptr_i   : highest-priority position
//   grant_o : one-hot grant on the first request at or after ptr_i (wrapping)
//   idx_o   : index of the granted request
//   any_o   : 1 when any request is present
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= N) pos = pos - N;
      if (!any_o && req_i[pos[IW-1:0]]) begin
        any_o                  = 1'b1;
        grant_o[pos[IW-1:0]]   = 1'b1;
        idx_o                  = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/decoder_scheduler.sv
// Shares one decoder between NUM_REQ requesters. Jobs are accepted one at a
// time in round-robin order, run on the decoder with a timeout, and the
// result is returned to the owning requester.
//   clk, rst     : clock, asynchronous active-high reset
//   req_if       : requester job / response bundle (slave side)
//   dec_enable   : decoder enable, high for the whole WAIT state
//   dec_rstring  : codeword to decoder (0 outside WAIT)
//   dec_size     : size code to decoder (0 outside WAIT)
//   dec_dstring  : decoded data from decoder
//   dec_done     : decoder completion
//   busy         : 1 whenever the scheduler is not IDLE
//
// state | meaning
// IDLE  | waiting for a job; req_ready one-hot on the round-robin grant
// WAIT  | decoder enabled, waiting for done or timeout
// RESP  | rsp_valid to owner, holding data/err until owner accepts
module decoder_scheduler
  import decoder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  decoder_scheduler_if.slave req_if,
  output logic              dec_enable,
  output logic [CW_W-1:0]   dec_rstring,
  output logic [SZ_W-1:0]   dec_size,
  input  logic [DW_W-1:0]   dec_dstring,
  input  logic              dec_done,
  output logic              busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_t     state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CW_W-1:0]  str_q, str_d;
  logic [SZ_W-1:0]  size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW_W-1:0]  data_q, data_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [CW_W-1:0]    sel_str;
  logic [SZ_W-1:0]    sel_size;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req_if.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  always_comb begin
    sel_str  = '0;
    sel_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_str  = req_if.req_string[i*CW_W +: CW_W];
        sel_size = req_if.req_size[i*SZ_W +: SZ_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      str_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      str_q   <= str_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    str_d   = str_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          str_d   = sel_str;
          size_d  = sel_size;
          owner_d = grant_idx;
          if (sel_size <= MAX_SIZE) begin
            state_d = WAIT;
          end else begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q == 0 is the first WAIT cycle: a done still high from the
        // previous job must not complete this one. Done beats timeout.
        if (dec_done && (cnt_q != '0)) begin
          data_d  = dec_dstring;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (req_if.rsp_ready[owner_q]) begin
          ptr_d   = PTR_W'(rr_next(int'(owner_q), NUM_REQ));
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst so no job can be offered while reset is asserted.
  assign req_if.req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign req_if.rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign req_if.rsp_data  = data_q;
  assign req_if.rsp_err   = err_q;

  assign dec_enable  = (state_q == WAIT);
  assign dec_rstring = (state_q == WAIT) ? str_q : '0;
  assign dec_size    = (state_q == WAIT) ? size_q : '0;
  assign busy        = (state_q != IDLE);

endmodule
